// File: rtl/fpu_issue_pkg.sv
// Shared COP1 encodings, scoreboard entry type and head-instruction decode
// for the FPU issue controller.
package fpu_issue_pkg;

   // COP1 major opcode
   localparam logic [5:0] OP_COP1 = 6'h11;

   // fmt field values (inst[25:21])
   localparam logic [4:0] FMT_MF = 5'h00;
   localparam logic [4:0] FMT_MT = 5'h04;
   localparam logic [4:0] FMT_S  = 5'h10;
   localparam logic [4:0] FMT_PS = 5'h16;

   // funct field values (inst[5:0]) of the arithmetic group
   localparam logic [5:0] FN_ADD = 6'h00;
   localparam logic [5:0] FN_SUB = 6'h01;
   localparam logic [5:0] FN_MUL = 6'h02;
   localparam logic [5:0] FN_DIV = 6'h03;

   // Instruction word presented to the FPU when nothing may issue
   localparam logic [31:0] BUBBLE = 32'h0;

   // Instruction classes the scoreboard cares about
   typedef enum logic [1:0] {
      CLS_OTHER,
      CLS_ARITH,
      CLS_MTC,
      CLS_MFC
   } inst_cls_t;

   // One scoreboard slot: an in-flight write to an FPR pair
   typedef struct packed {
      logic       valid;
      logic [3:0] pair;
   } sb_entry_t;

   // Register usage of one instruction
   typedef struct packed {
      logic       writes;
      logic [3:0] dest;
      logic       rd_fs;
      logic       rd_ft;
   } dec_t;

   // Classify a word; anything not recognised is CLS_OTHER
   function automatic inst_cls_t fpu_classify(input logic [31:0] inst);
      logic cop1;
      cop1 = (inst[31:26] == OP_COP1);
      if (cop1 && (inst[5:0] <= FN_DIV) && inst[25])
         return CLS_ARITH;
      else if (cop1 && (inst[25:21] == FMT_MT) && (inst[10:0] == 11'h0))
         return CLS_MTC;
      else if (cop1 && (inst[25:21] == FMT_MF) && (inst[10:0] == 11'h0))
         return CLS_MFC;
      else
         return CLS_OTHER;
   endfunction

   // Pair-level register usage: arith writes fd, mtc writes fs;
   // arith reads fs and ft, mfc reads fs
   function automatic dec_t fpu_decode(input logic [31:0] inst);
      dec_t      d;
      inst_cls_t cls;
      cls      = fpu_classify(inst);
      d        = '0;
      unique case (cls)
         CLS_ARITH: begin
            d.writes = 1'b1;
            d.dest   = inst[10:7];
            d.rd_fs  = 1'b1;
            d.rd_ft  = 1'b1;
         end
         CLS_MTC: begin
            d.writes = 1'b1;
            d.dest   = inst[15:12];
         end
         CLS_MFC: begin
            d.rd_fs  = 1'b1;
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// Synchronous instruction FIFO, DEPTH entries (power of two, >= 2).
// No bypass: a word written this cycle appears on data_o next cycle.
module fpu_issue_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // Storage array; contents need no reset since count gates validity
   always_ff @(posedge clk_i) begin
      if (do_push)
         mem_q[wr_ptr_q] <= data_i;
   end

   // Pointers wrap naturally at DEPTH; count tracks occupancy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// COP1 issue controller: FIFO-buffers instructions from the core, issues
// one per cycle to the FPU, and inserts bubbles on FPR-pair RAW hazards
// against a two-slot scoreboard mirroring the FPU EX and WB stages, or
// while the FPU holds.
// Optional feature macro: FPU_ISSUE_PERF_EN enables perf counters;
// without it perf_issued/perf_bubbles read as zero.
module fpu_issue_ctrl
   import fpu_issue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic        fpu_hold,
   output logic [31:0] fpu_inst,
   output logic        issue,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_bubbles
);

   logic        fifo_full, fifo_empty;
   logic        push;
   logic [31:0] head;
   logic        head_valid;
   logic        hazard;
   dec_t        dec;
   sb_entry_t   sb_ex_q, sb_ex_d, sb_wb_q;

   assign in_ready   = ~fifo_full & ~rst;
   assign push       = in_valid & in_ready;
   assign head_valid = ~fifo_empty;

   fpu_issue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .data_i  (in_inst),
      .pop_i   (issue),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Hazard check of the head against both in-flight writes, then issue
   always_comb begin
      hazard   = 1'b0;
      fpu_inst = BUBBLE;
      issue    = 1'b0;
      sb_ex_d  = '0;
      dec      = fpu_decode(head);
      if (dec.rd_fs &&
          ((sb_ex_q.valid && sb_ex_q.pair == head[15:12]) ||
           (sb_wb_q.valid && sb_wb_q.pair == head[15:12])))
         hazard = 1'b1;
      if (dec.rd_ft &&
          ((sb_ex_q.valid && sb_ex_q.pair == head[20:17]) ||
           (sb_wb_q.valid && sb_wb_q.pair == head[20:17])))
         hazard = 1'b1;
      if (head_valid && !hazard) begin
         fpu_inst = head;
         issue    = ~fpu_hold;
      end
      if (issue && dec.writes) begin
         sb_ex_d.valid = 1'b1;
         sb_ex_d.pair  = dec.dest;
      end
   end

   // Scoreboard shifts with the FPU pipeline and freezes with it on hold
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_ex_q <= '0;
         sb_wb_q <= '0;
      end else if (!fpu_hold) begin
         sb_ex_q <= sb_ex_d;
         sb_wb_q <= sb_ex_q;
      end
   end

`ifdef FPU_ISSUE_PERF_EN
   logic [31:0] perf_issued_q, perf_bubbles_q;

   // Issue and bubble counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued_q  <= '0;
         perf_bubbles_q <= '0;
      end else begin
         if (issue)
            perf_issued_q <= perf_issued_q + 32'd1;
         if (head_valid && !issue)
            perf_bubbles_q <= perf_bubbles_q + 32'd1;
      end
   end

   assign perf_issued  = perf_issued_q;
   assign perf_bubbles = perf_bubbles_q;
`else
   assign perf_issued  = '0;
   assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl (DEPTH=4): vector table for the RAW
// distance cases, hand sequences for hold, full FIFO and reset.
module tb_fpu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic        fpu_hold;
   logic [31:0] fpu_inst;
   logic        issue;
   logic [31:0] perf_issued;
   logic [31:0] perf_bubbles;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_inst      (in_inst),
      .fpu_hold     (fpu_hold),
      .fpu_inst     (fpu_inst),
      .issue        (issue),
      .perf_issued  (perf_issued),
      .perf_bubbles (perf_bubbles)
   );

   typedef struct {
      logic        v;
      logic [31:0] w;
      logic        h;
      logic        er;
      logic [31:0] ei;
      logic        es;
      int unsigned ni;
      int unsigned nb;
   } vec_t;

   vec_t tbl [19];

   localparam logic [31:0] ADD_A = 32'h46061100; // add.s f4,f2,f6
   localparam logic [31:0] ADD_B = 32'h46061280; // add.s f10,f2,f6
   localparam logic [31:0] ADD_C = 32'h46042200; // add.s f8,f4,f4
   localparam logic [31:0] MTC4  = 32'h44812000; // mtc1 r1,f4
   localparam logic [31:0] MFC4  = 32'h44022000; // mfc1 r2,f4
   localparam logic [31:0] MFC5  = 32'h44022800; // mfc1 r2,f5
   localparam logic [31:0] DIV_D = 32'h46061103; // div.s f4,f2,f6

   // Expected perf value: counters read zero when the feature is absent
   function automatic logic [31:0] pv(input int unsigned n);
      logic [31:0] r;
      r = n;
`ifndef FPU_ISSUE_PERF_EN
      r = '0;
`endif
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic v, input logic [31:0] w, input logic h,
                      input logic er, input logic [31:0] ei, input logic es);
      in_valid = v;
      in_inst  = w;
      fpu_hold = h;
      @(negedge clk);
      chk($sformatf("%s.in_ready", tag), 32'(in_ready), 32'(er));
      chk($sformatf("%s.fpu_inst", tag), fpu_inst, ei);
      chk($sformatf("%s.issue", tag), 32'(issue), 32'(es));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_perf(input string tag, input int unsigned ni, input int unsigned nb);
      chk($sformatf("%s.perf_issued", tag), perf_issued, pv(ni));
      chk($sformatf("%s.perf_bubbles", tag), perf_bubbles, pv(nb));
   endtask

   initial begin
      // back-to-back independent
      tbl[0]  = '{1'b1, ADD_A, 1'b0, 1'b1, 32'h0, 1'b0, 0, 0};
      tbl[1]  = '{1'b1, ADD_B, 1'b0, 1'b1, ADD_A, 1'b1, 0, 0};
      tbl[2]  = '{1'b0, 32'h0, 1'b0, 1'b1, ADD_B, 1'b1, 1, 0};
      tbl[3]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 2, 0};
      tbl[4]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 2, 0};
      // dependent add: two bubbles
      tbl[5]  = '{1'b1, ADD_A, 1'b0, 1'b1, 32'h0, 1'b0, 2, 0};
      tbl[6]  = '{1'b1, ADD_C, 1'b0, 1'b1, ADD_A, 1'b1, 2, 0};
      tbl[7]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 3, 0};
      tbl[8]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 3, 1};
      tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b1, ADD_C, 1'b1, 3, 2};
      tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 4, 2};
      tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 4, 2};
      // mtc1 -> mfc1 on same pair, then mfc1 of odd half
      tbl[12] = '{1'b1, MTC4,  1'b0, 1'b1, 32'h0, 1'b0, 4, 2};
      tbl[13] = '{1'b1, MFC4,  1'b0, 1'b1, MTC4,  1'b1, 4, 2};
      tbl[14] = '{1'b1, MFC5,  1'b0, 1'b1, 32'h0, 1'b0, 5, 2};
      tbl[15] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 5, 3};
      tbl[16] = '{1'b0, 32'h0, 1'b0, 1'b1, MFC4,  1'b1, 5, 4};
      tbl[17] = '{1'b0, 32'h0, 1'b0, 1'b1, MFC5,  1'b1, 6, 4};
      tbl[18] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 7, 4};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_inst  = 32'h0;
      fpu_hold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'h0);
      chk("rst.fpu_inst", fpu_inst, 32'h0);
      chk("rst.issue", 32'(issue), 32'h0);
      chk_perf("rst", 0, 0);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         in_valid = tbl[i].v;
         in_inst  = tbl[i].w;
         fpu_hold = tbl[i].h;
         @(negedge clk);
         chk($sformatf("row%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].er));
         chk($sformatf("row%0d.fpu_inst", i), fpu_inst, tbl[i].ei);
         chk($sformatf("row%0d.issue", i), 32'(issue), 32'(tbl[i].es));
         chk_perf($sformatf("row%0d", i), tbl[i].ni, tbl[i].nb);
         @(posedge clk);
         #1;
      end

      // hold after div.s: E stays visible, scoreboard frozen so ADD_C still
      // sees the div in WB one cycle after hold falls
      cyc("hold0", 1'b1, DIV_D, 1'b0, 1'b1, 32'h0, 1'b0);
      cyc("hold1", 1'b1, ADD_B, 1'b0, 1'b1, DIV_D, 1'b1);
      cyc("hold2", 1'b1, ADD_C, 1'b1, 1'b1, ADD_B, 1'b0);
      for (int i = 0; i < 4; i++)
         cyc($sformatf("hold%0d", 3 + i), 1'b0, 32'h0, 1'b1, 1'b1, ADD_B, 1'b0);
      cyc("hold7", 1'b0, 32'h0, 1'b0, 1'b1, ADD_B, 1'b1);
      cyc("hold8", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
      cyc("hold9", 1'b0, 32'h0, 1'b0, 1'b1, ADD_C, 1'b1);
      cyc("hold10", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
      cyc("hold11", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
      chk_perf("hold", 10, 10);

      // full FIFO under hold; fifth word waits for the first pop
      cyc("full0", 1'b1, 32'hA0000001, 1'b1, 1'b1, 32'h0, 1'b0);
      cyc("full1", 1'b1, 32'hA0000002, 1'b1, 1'b1, 32'hA0000001, 1'b0);
      cyc("full2", 1'b1, 32'hA0000003, 1'b1, 1'b1, 32'hA0000001, 1'b0);
      cyc("full3", 1'b1, 32'hA0000004, 1'b1, 1'b1, 32'hA0000001, 1'b0);
      cyc("full4", 1'b1, 32'hA0000005, 1'b1, 1'b0, 32'hA0000001, 1'b0);
      cyc("full5", 1'b1, 32'hA0000005, 1'b1, 1'b0, 32'hA0000001, 1'b0);
      cyc("full6", 1'b1, 32'hA0000005, 1'b0, 1'b0, 32'hA0000001, 1'b1);
      cyc("full7", 1'b1, 32'hA0000005, 1'b0, 1'b1, 32'hA0000002, 1'b1);
      cyc("full8", 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0000003, 1'b1);
      cyc("full9", 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0000004, 1'b1);
      cyc("full10", 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0000005, 1'b1);
      cyc("full11", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
      chk_perf("full", 15, 15);

      // reset with three queued words and the add in sb_ex (frozen by hold)
      cyc("rq0", 1'b1, ADD_A, 1'b0, 1'b1, 32'h0, 1'b0);
      cyc("rq1", 1'b1, ADD_C, 1'b0, 1'b1, ADD_A, 1'b1);
      cyc("rq2", 1'b1, 32'hA0000011, 1'b1, 1'b1, 32'h0, 1'b0);
      cyc("rq3", 1'b1, 32'hA0000012, 1'b1, 1'b1, 32'h0, 1'b0);
      rst      = 1'b1;
      in_valid = 1'b0;
      fpu_hold = 1'b0;
      @(negedge clk);
      chk("rq4.in_ready", 32'(in_ready), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rq5.fpu_inst", fpu_inst, 32'h0);
      chk("rq5.issue", 32'(issue), 32'h0);
      chk_perf("rq5", 0, 0);
      // reads f4 pair: issues at once only if the scoreboard was cleared
      cyc("rq5", 1'b1, ADD_C, 1'b0, 1'b1, 32'h0, 1'b0);
      cyc("rq6", 1'b0, 32'h0, 1'b0, 1'b1, ADD_C, 1'b1);
      cyc("rq7", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
      chk_perf("rq7", 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue controller between the integer core and the three-stage COP1 unit (ID/EX/WB). It buffers COP1 instructions in a small FIFO and presents them to the FPU `inst` input one per cycle. It tracks in-flight FPR writes in a two-entry scoreboard that mirrors the FPU's EX and WB stages. It inserts bubbles (`32'h0`) whenever the next instruction would read an FPR pair that has not yet been written back, or while the FPU asserts `hold`.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  core offers `in_inst`.
- `in_ready`  out  1  FIFO can accept; equals `~full & ~rst`.
- `in_inst`  in  32  COP1 instruction word.
- `fpu_hold`  in  1  FPU `hold` (divider busy).
- `fpu_inst`  out  32  instruction to FPU `inst`; `32'h0` is a bubble.
- `issue`  out  1  a real instruction is accepted by the FPU this cycle.
- `perf_issued`  out  32  issued-instruction count (see Configuration).
- `perf_bubbles`  out  32  hazard/hold bubble count (see Configuration).

## Operation
- **FIFO:**
  - Push on `in_valid & in_ready`.
  - Head is valid when count > 0.
  - No bypass: an instruction written this cycle is issuable next cycle at the earliest.
- **Decode of the head instruction:**
  - `cop1 = inst[31:26]==6'h11`.
  - `arith = cop1 & inst[5:0]<=3 & inst[25]` (fmt[4]).
  - `mtc = cop1 & fmt==5'h04 & inst[10:0]==0`.
  - `mfc = cop1 & fmt==5'h00 & inst[10:0]==0`.
  - Writes: `arith` → pair `fd[4:1]`; `mtc` → pair `fs[4:1]`.
  - Reads: `arith` → pairs `fs[4:1]` and `ft[4:1]`; `mfc` → pair `fs[4:1]`; `mtc` reads none.
  - Any other word writes and reads nothing and issues unconditionally.
- **Scoreboard:** two slots `sb_ex` and `sb_wb`, each {valid, pair[3:0]}.
- **Hazard:** a read pair equals a valid `sb_ex.pair` or `sb_wb.pair`. Hazards are compared at pair granularity, so f4 and f5 conflict.
- **Issue:**
  - `fpu_inst = (head_valid & ~hazard) ? head : 32'h0`.
  - `issue = head_valid & ~hazard & ~fpu_hold`.
  - Pop on `issue`.
- **Scoreboard advance, only when `~fpu_hold`:**
  - `sb_ex <= issue ? {writes, dest} : 0`.
  - `sb_wb <= sb_ex`.
  - When `fpu_hold` is high, both slots hold their values, exactly like the FPU pipeline registers.
- **Simultaneous push and pop:** both take effect and the count is unchanged. When full, `in_ready=0` even if a pop occurs in the same cycle.

## Timing
- **Reset values:**
  - FIFO empty; `sb_ex` and `sb_wb` invalid.
  - `fpu_inst=0`, `issue=0`, `perf_*=0`.
  - `in_ready=0` while `rst` is high, 1 on the first cycle after reset.
- Asserting `rst` mid-operation discards the FIFO contents and the scoreboard in the same edge.
- **Latency:** an instruction pushed at edge N reaches `fpu_inst` in cycle N+1 when there is no hazard and no hold.
- **RAW distance:** a consumer immediately following its producer sees 2 bubble cycles. A consumer with one independent instruction between sees 1 bubble. Two or more intervening instructions give no bubble.
- **During `fpu_hold`:** `fpu_inst` keeps showing the hazard-free head, nothing pops, and issue resumes on the first cycle after `hold` falls.

## Configuration
- Macro `FPU_ISSUE_PERF_EN`.
- **Defined:**
  - `perf_issued` increments on `issue`.
  - `perf_bubbles` increments each cycle with `head_valid & ~issue`.
  - Both counters wrap at 2^32 and clear on `rst`.
- **Undefined:** both ports are tied to `32'h0` and no counter flops exist.

## Structure
- **Package `fpu_issue_pkg`:**
  - COP1 constants: opcode `6'h11`, fmt MF/MT/S/PS, funct ADD–DIV.
  - Scoreboard entry struct {valid, pair}.
  - Decode function returning {writes, dest, rd_fs, rd_ft}.
- **Sub-module `fpu_issue_fifo`:** DEPTH-parameterized synchronous FIFO with count, full and empty.
- The hazard logic and scoreboard stay in the top module.

## Test plan
- **Back-to-back independent instructions:** push `46061100` (add.s f4,f2,f6) then `46061280` (add.s f10,f2,f6) → issued in consecutive cycles; `perf_bubbles=0`.
- **Dependent add:** push `46061100` then `46042200` (add.s f8,f4,f4) → `fpu_inst` sequence `46061100`, 0, 0, `46042200`; `perf_bubbles=2`.
- **MTC then MFC:** `44812000` (mtc1 r1,f4) then `44022000` (mfc1 r2,f4) → 2 bubbles. A following mfc1 of f5 (`44022800`) issues right after `44022000` with no extra bubble.
- **Hold:** `fpu_hold` high for 5 cycles after a div.s issue → no pop and scoreboard frozen during those cycles; the next instruction issues on the first cycle after `hold` falls.
- **Full FIFO:** DEPTH=4, `fpu_hold` held high, push 5 words → `in_ready=0` after 4 pushes; the 5th is accepted only after the first pop.
- **Reset with pending work:** assert `rst` with 3 entries queued and `sb_ex` valid → next cycle `fpu_inst=0`, `issue=0`, counters 0; a new independent instruction issues without a bubble.
